// File: rtl/store_seq_ctrl_if.sv
// Store-request and dmem write-port signals shared by the core, the store
// sequencer and the data memory.
interface store_seq_ctrl_if;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        stall;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;

    // Environment side: core issues stores, memory returns grants.
    modport master (
        output st_valid, st_funct3, st_addr, st_data, mem_gnt,
        input  st_ready, stall, st_done, st_err,
        input  mem_req, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, mem_gnt,
        output st_ready, stall, st_done, st_err,
        output mem_req, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/store_seq_ctrl.sv
// Sequences SB/SH/SW stores onto the dmem write port, building lane-aligned data
// and byte enables and splitting word-crossing stores into two beats.
module store_seq_ctrl #(
    parameter bit SPLIT_EN = 1'b1,
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    store_seq_ctrl_if.slave bus
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WW'(MAX_WAIT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [29:0]   word_q;
    logic [7:0]    we_q;
    logic [63:0]   data_q;
    logic          err_q;
    logic [WW-1:0] wait_q;

    logic [1:0]    off;
    logic [7:0]    base_mask;
    logic [7:0]    mask;
    logic [63:0]   shifted;
    logic          legal;
    logic          split;
    logic          reject;
    logic          accept;
    logic          grant;
    logic          timeout;

    // Lane math over an 8-byte window: the upper nibble of the mask is the second word.
    always_comb begin
        off       = bus.st_addr[1:0];
        legal     = 1'b1;
        base_mask = 8'h00;
        case (bus.st_funct3)
            3'b000:  base_mask = 8'h01;
            3'b001:  base_mask = 8'h03;
            3'b010:  base_mask = 8'h0F;
            default: legal = 1'b0;
        endcase
        mask    = base_mask << off;
        shifted = {32'b0, bus.st_data} << {off, 3'b000};
        split   = |mask[7:4];
        reject  = !legal || (split && !SPLIT_EN);
    end

    assign accept  = bus.st_valid && (state == IDLE);
    assign grant   = bus.mem_req && bus.mem_gnt;
    assign timeout = (MAX_WAIT != 0) && bus.mem_req && !bus.mem_gnt && (wait_q == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = reject ? DONE : BEAT0;
            BEAT0: begin
                if (grant)        state_nxt = (|we_q[7:4]) ? BEAT1 : DONE;
                else if (timeout) state_nxt = DONE;
            end
            BEAT1:   if (grant || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs decode straight from state so an async reset drops mem_req at once.
    assign bus.st_ready  = (state == IDLE);
    assign bus.stall     = (state != IDLE);
    assign bus.st_done   = (state == DONE);
    assign bus.st_err    = (state == DONE) && err_q;
    assign bus.mem_req   = (state == BEAT0) || (state == BEAT1);
    assign bus.mem_addr  = (state == BEAT0) ? {word_q, 2'b00} :
                           (state == BEAT1) ? {word_q + 30'd1, 2'b00} : 32'd0;
    assign bus.mem_we    = (state == BEAT0) ? we_q[3:0] :
                           (state == BEAT1) ? we_q[7:4] : 4'd0;
    assign bus.mem_wdata = (state == BEAT0) ? data_q[31:0] :
                           (state == BEAT1) ? data_q[63:32] : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            word_q <= '0;
            we_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            wait_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_q <= bus.st_addr[31:2];
                we_q   <= mask;
                data_q <= shifted;
                err_q  <= reject;
            end else if (timeout) begin
                err_q  <= 1'b1;
            end
            // Each beat gets its own full wait budget.
            if (accept || ((state == BEAT0) && grant)) begin
                wait_q <= '0;
            end else if (bus.mem_req && !bus.mem_gnt) begin
                wait_q <= wait_q + WW'(1);
            end
        end
    end
endmodule

// File: tb/tb_store_seq_ctrl.sv
// Randomised and directed stores against a byte-level reference model; a monitor
// pops expected beats and completions from per-instance scoreboards.
module tb_store_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } beat_t;

    store_seq_ctrl_if bus0();
    store_seq_ctrl_if bus1();

    // Instance 0 splits and times out after 16 cycles; instance 1 rejects splits and waits forever.
    store_seq_ctrl #(.SPLIT_EN(1'b1), .MAX_WAIT(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    store_seq_ctrl #(.SPLIT_EN(1'b0), .MAX_WAIT(0))  dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic        st_valid  [2];
    logic [2:0]  st_funct3 [2];
    logic [31:0] st_addr   [2];
    logic [31:0] st_data   [2];
    logic        gnt;

    assign bus0.st_valid  = st_valid[0];
    assign bus0.st_funct3 = st_funct3[0];
    assign bus0.st_addr   = st_addr[0];
    assign bus0.st_data   = st_data[0];
    assign bus0.mem_gnt   = gnt;
    assign bus1.st_valid  = st_valid[1];
    assign bus1.st_funct3 = st_funct3[1];
    assign bus1.st_addr   = st_addr[1];
    assign bus1.st_data   = st_data[1];
    assign bus1.mem_gnt   = gnt;

    beat_t bq0[$];
    beat_t bq1[$];
    logic  eq0[$];
    logic  eq1[$];

    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    int    dcnt [2];
    int    last_done_cyc [2];
    int    gnt_mode = 1;
    bit    granted_once = 1'b0;
    logic  prev_req [2];
    logic  prev_gnt [2];
    beat_t prev_beat [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Grant policy: 0 random (3 in 4), 1 always, 2 never, 3 only the first requested cycle.
    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0: gnt = ($urandom_range(0, 3) != 0);
            1: gnt = 1'b1;
            2: gnt = 1'b0;
            default: begin
                gnt = (bus0.mem_req || bus1.mem_req) && !granted_once;
                if (gnt) granted_once = 1'b1;
            end
        endcase
    end

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.st_ready : bus1.st_ready;
    endfunction

    function automatic logic reqf(input int d);
        return (d == 0) ? bus0.mem_req : bus1.mem_req;
    endfunction

    // Reference: store byte k lands at byte offset off+k of an 8-byte window spanning two words.
    function automatic void model_push(input int d, input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] dt, input int ngrant, input bit push_done);
        int         size;
        int         off;
        int         nb;
        logic [7:0] lane [8];
        logic       en [8];
        logic       err;
        beat_t      b;
        case (f)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: size = 0;
        endcase
        err = 1'b0;
        nb  = 0;
        off = int'(a[1:0]);
        for (int i = 0; i < 8; i++) begin
            lane[i] = 8'h00;
            en[i]   = 1'b0;
        end
        if (size == 0) begin
            err = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                lane[off + k] = dt[8*k +: 8];
                en[off + k]   = (k < size);
            end
            nb = (off + size > 4) ? 2 : 1;
            if (nb == 2 && d == 1) begin
                err = 1'b1;
                nb  = 0;
            end
        end
        for (int i = 0; i < nb; i++) begin
            if (i < ngrant) begin
                b.addr = (a & 32'hFFFF_FFFC) + 32'(4 * i);
                for (int l = 0; l < 4; l++) begin
                    b.we[l]          = en[4*i + l];
                    b.wdata[8*l +: 8] = lane[4*i + l];
                end
                if (d == 0) bq0.push_back(b);
                else        bq1.push_back(b);
            end else begin
                err = 1'b1;
            end
        end
        if (push_done) begin
            if (d == 0) eq0.push_back(err);
            else        eq1.push_back(err);
        end
    endfunction

    task automatic monitor(input int d, input logic req, input logic g, input beat_t cur,
                           input logic done, input logic err, input logic stall, input logic ready);
        beat_t e;
        logic  ee;
        int    qs;
        if (req && g) begin
            qs = (d == 0) ? bq0.size() : bq1.size();
            if (qs == 0) begin
                checks++;
                $display("[TB] FAIL dut%0d beat: got unexpected beat %h, expected none", d, cur);
            end else begin
                if (d == 0) e = bq0.pop_front();
                else        e = bq1.pop_front();
                check_output($sformatf("dut%0d beat", d), 96'(cur), 96'(e));
            end
        end
        if (prev_req[d] && !prev_gnt[d] && req)
            check_output($sformatf("dut%0d held beat", d), 96'(cur), 96'(prev_beat[d]));
        if (err && !done) begin
            checks++;
            $display("[TB] FAIL dut%0d err without done: got st_err=1, expected 0", d);
        end
        if (done) begin
            dcnt[d]++;
            last_done_cyc[d] = cyc;
            qs = (d == 0) ? eq0.size() : eq1.size();
            if (qs == 0) begin
                checks++;
                $display("[TB] FAIL dut%0d done: got unexpected st_done, expected none", d);
            end else begin
                if (d == 0) ee = eq0.pop_front();
                else        ee = eq1.pop_front();
                check_output($sformatf("dut%0d err/stall/ready/req at done", d),
                             96'({err, stall, ready, req}), 96'({ee, 1'b1, 1'b0, 1'b0}));
            end
        end
        prev_req[d]  = req;
        prev_gnt[d]  = g;
        prev_beat[d] = cur;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            monitor(0, bus0.mem_req, gnt, {bus0.mem_addr, bus0.mem_we, bus0.mem_wdata},
                    bus0.st_done, bus0.st_err, bus0.stall, bus0.st_ready);
            monitor(1, bus1.mem_req, gnt, {bus1.mem_addr, bus1.mem_we, bus1.mem_wdata},
                    bus1.st_done, bus1.st_err, bus1.stall, bus1.st_ready);
        end else begin
            prev_req[0] = 1'b0;
            prev_req[1] = 1'b0;
        end
    end

    // exp_lat / exp_reqc < 0 skip the timing checks; wait_done=0 leaves the store in flight.
    task automatic apply_stimulus(input int d, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] dt, input int ngrant, input int exp_lat,
                                  input int exp_reqc, input bit wait_done);
        int n;
        int acc;
        int snap;
        int reqc;
        model_push(d, f, a, dt, ngrant, wait_done);
        n = 0;
        @(negedge clk);
        while (!rdy(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("[TB] FAIL dut%0d ready wait: got st_ready=0 for 100 cycles, expected 1", d);
        end
        st_valid[d]  = 1'b1;
        st_funct3[d] = f;
        st_addr[d]   = a;
        st_data[d]   = dt;
        snap = dcnt[d];
        @(posedge clk);
        acc = cyc;
        #1;
        st_valid[d] = 1'b0;
        if (wait_done) begin
            n    = 0;
            reqc = 0;
            while (dcnt[d] == snap && n < 200) begin
                @(negedge clk);
                if (reqf(d)) reqc++;
                n++;
            end
            if (dcnt[d] == snap) begin
                checks++;
                $display("[TB] FAIL dut%0d done wait: got no st_done in 200 cycles, expected one", d);
            end else begin
                if (exp_lat >= 0) begin
                    check_output($sformatf("dut%0d done latency", d),
                                 96'(last_done_cyc[d] - acc), 96'(exp_lat));
                    while (cyc < last_done_cyc[d] + 1) @(negedge clk);
                    check_output($sformatf("dut%0d ready after done", d), 96'(rdy(d)), 96'(1));
                end
                if (exp_reqc >= 0)
                    check_output($sformatf("dut%0d req cycles", d), 96'(reqc), 96'(exp_reqc));
            end
        end
    endtask

    task automatic rnd_store(input int d);
        int          r;
        logic [2:0]  f;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 3)      f = 3'b000;
        else if (r < 6) f = 3'b001;
        else if (r < 9) f = 3'b010;
        else            f = 3'($urandom_range(3, 7));
        a = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | {30'b0, a[1:0]};
        apply_stimulus(d, f, a, $urandom, 9, -1, -1, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            st_valid[i]      = 1'b0;
            st_funct3[i]     = 3'b000;
            st_addr[i]       = 32'd0;
            st_data[i]       = 32'd0;
            dcnt[i]          = 0;
            last_done_cyc[i] = 0;
            prev_req[i]      = 1'b0;
            prev_gnt[i]      = 1'b0;
            prev_beat[i]     = '0;
        end
        gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("dut0 reset outputs",
                     96'({bus0.st_ready, bus0.stall, bus0.st_done, bus0.st_err, bus0.mem_req,
                          bus0.mem_addr, bus0.mem_we, bus0.mem_wdata}), 96'({1'b1, 72'b0}));
        check_output("dut1 reset outputs",
                     96'({bus1.st_ready, bus1.stall, bus1.st_done, bus1.st_err, bus1.mem_req,
                          bus1.mem_addr, bus1.mem_we, bus1.mem_wdata}), 96'({1'b1, 72'b0}));
        @(negedge clk);
        reset = 1'b1;

        gnt_mode = 1;
        apply_stimulus(0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 9, 2, 1, 1'b1);
        apply_stimulus(0, 3'b000, 32'h0000_0103, 32'h0000_00AB, 9, 2, 1, 1'b1);
        apply_stimulus(0, 3'b001, 32'h0000_0103, 32'h0000_1234, 9, 3, 2, 1'b1);
        apply_stimulus(0, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 9, 3, 2, 1'b1);
        apply_stimulus(0, 3'b011, 32'h0000_0100, 32'h0000_0005, 9, 1, 0, 1'b1);
        apply_stimulus(1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 9, 1, 0, 1'b1);
        apply_stimulus(1, 3'b001, 32'h0000_0102, 32'h0000_CAFE, 9, 2, 1, 1'b1);
        apply_stimulus(1, 3'b000, 32'h0000_0201, 32'h0000_0077, 9, 2, 1, 1'b1);

        gnt_mode = 2;
        apply_stimulus(0, 3'b010, 32'h0000_0200, 32'h0000_0001, 0, 17, 16, 1'b1);
        gnt_mode = 3;
        granted_once = 1'b0;
        apply_stimulus(0, 3'b001, 32'h0000_0303, 32'h0000_BEEF, 1, 18, 17, 1'b1);

        // Abort a split store while its second beat is waiting for a grant.
        granted_once = 1'b0;
        apply_stimulus(0, 3'b010, 32'h0001_0001, 32'hA5A5_A5A5, 1, -1, -1, 1'b0);
        @(posedge clk);
        #2;
        check_output("dut0 beat1 pending", 96'({bus0.mem_req, bus0.mem_addr}), 96'({1'b1, 32'h0001_0004}));
        reset = 1'b0;
        #1;
        check_output("dut0 async abort", 96'({bus0.mem_req, bus0.stall, bus0.st_ready}), 96'(3'b001));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("dut0 ready after reset", 96'(bus0.st_ready), 96'(1));

        gnt_mode = 0;
        for (int i = 0; i < 200; i++) rnd_store(0);
        for (int i = 0; i < 60; i++)  rnd_store(1);

        repeat (3) @(negedge clk);
        check_output("dut0 scoreboard drained", 96'(bq0.size() + eq0.size()), 96'(0));
        check_output("dut1 scoreboard drained", 96'(bq1.size() + eq1.size()), 96'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
